// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer: prescaled up-counter, compare match with a sticky flag,
// optional periodic auto-reload and a level interrupt, on a single-cycle-latency bus.
module bus_timer #(
  parameter int unsigned PRESCALE_DIV = 1,
  parameter logic [31:0] CMP_RESET    = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        irq
);

  localparam int unsigned PsW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE_DIV - 1);

  typedef enum logic [1:0] {
    RegCount   = 2'd0,
    RegCompare = 2'd1,
    RegCtrl    = 2'd2,
    RegStatus  = 2'd3
  } reg_e;

  logic [31:0]    count_q, count_d;
  logic [31:0]    compare_q, compare_d;
  logic [2:0]     ctrl_q, ctrl_d;      // {IRQ_EN, PERIODIC, EN}
  logic           match_q, match_d;
  logic [PsW-1:0] presc_q, presc_d;
  logic           ready_q, ready_d;
  logic [31:0]    rdata_q, rdata_d;

  logic        accept;
  logic        wr_en;
  reg_e        reg_sel;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_ctrl;
  logic        clr_match;
  logic        tick;
  logic        hit;
  logic [31:0] rd_val;

  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:4], mem_addr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    accept     = mem_valid & enable & ~ready_q;
    wr_en      = accept & (|mem_wstrb);
    reg_sel    = reg_e'(mem_addr[3:2]);
    wr_count   = wr_en & (reg_sel == RegCount);
    wr_compare = wr_en & (reg_sel == RegCompare);
    wr_ctrl    = wr_en & (reg_sel == RegCtrl) & mem_wstrb[0];
    clr_match  = wr_en & (reg_sel == RegStatus) & mem_wstrb[0] & mem_wdata[0];
    tick       = ctrl_q[0] & (presc_q == PsLast);
    hit        = tick & (count_q == compare_q);
  end

  always_comb begin
    rd_val = 32'h0;
    unique case (reg_sel)
      RegCount:   rd_val = count_q;
      RegCompare: rd_val = compare_q;
      RegCtrl:    rd_val = {29'h0, ctrl_q};
      RegStatus:  rd_val = {31'h0, match_q};
      default:    rd_val = 32'h0;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    ready_d   = accept;
    rdata_d   = accept ? rd_val : 32'h0;

    if (!ctrl_q[0] || wr_count || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PsW'(1);
    end

    // A COUNT write wins over the tick's increment/reload.
    if (wr_count) begin
      count_d = merge_bytes(count_q, mem_wdata, mem_wstrb);
    end else if (tick) begin
      count_d = (hit && ctrl_q[1]) ? 32'h0 : count_q + 32'd1;
    end

    if (wr_compare) compare_d = merge_bytes(compare_q, mem_wdata, mem_wstrb);
    if (wr_ctrl)    ctrl_d    = mem_wdata[2:0];

    // A match set in the same cycle beats the write-one-to-clear.
    match_d = (match_q & ~clr_match) | hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'h0;
      compare_q <= CMP_RESET;
      ctrl_q    <= 3'h0;
      match_q   <= 1'b0;
      presc_q   <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      match_q   <= match_d;
      presc_q   <= presc_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign irq       = match_q & ctrl_q[2];

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus a randomized phase, all
// checked every cycle against a behavioural model of the timer.
module tb_bus_timer;

  localparam int Div = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_count, m_cmp, m_rdata;
  logic        m_en, m_per, m_ie, m_match, m_ready;
  int          m_ps;

  bus_timer #(
    .PRESCALE_DIV(Div),
    .CMP_RESET   (32'hFFFFFFFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0:       return m_count;
      1:       return m_cmp;
      2:       return {29'h0, m_ie, m_per, m_en};
      default: return {31'h0, m_match};
    endcase
  endfunction

  // Advance one clock: model the effect of the current inputs, then compare outputs.
  task automatic cycle();
    logic        acc, wr, tick, hit;
    int          idx, n_ps;
    logic [31:0] nc, ncmp, nrd;
    logic        nen, nper, nie, nm, nrdy;
    acc  = mem_valid && enable && !m_ready;
    wr   = acc && (mem_wstrb != 4'h0);
    idx  = int'(mem_addr[3:2]);
    nc   = m_count;  ncmp = m_cmp;
    nen  = m_en;     nper = m_per;  nie = m_ie;  nm = m_match;
    tick = m_en && (m_ps == Div - 1);
    hit  = tick && (m_count == m_cmp);
    n_ps = (m_en && !tick) ? m_ps + 1 : 0;
    if (tick) nc = (hit && m_per) ? 32'h0 : m_count + 32'd1;
    nrdy = acc;
    nrd  = acc ? m_read(idx) : 32'h0;
    if (wr) begin
      case (idx)
        0: begin nc = merge(m_count, mem_wdata, mem_wstrb); n_ps = 0; end
        1: ncmp = merge(m_cmp, mem_wdata, mem_wstrb);
        2: if (mem_wstrb[0]) {nie, nper, nen} = mem_wdata[2:0];
        default: if (mem_wstrb[0] && mem_wdata[0]) nm = 1'b0;
      endcase
    end
    if (hit) nm = 1'b1;
    if (reset) begin
      nc = 32'h0; ncmp = 32'hFFFFFFFF; nen = 0; nper = 0; nie = 0; nm = 0;
      n_ps = 0; nrdy = 0; nrd = 32'h0;
    end
    @(posedge clk);
    #1;
    m_count = nc; m_cmp = ncmp; m_en = nen; m_per = nper; m_ie = nie; m_match = nm;
    m_ps = n_ps; m_ready = nrdy; m_rdata = nrd;
    check("model_ready", {31'h0, mem_ready}, {31'h0, m_ready});
    check("model_rdata", mem_rdata, m_rdata);
    check("model_irq", {31'h0, irq}, {31'h0, m_match & m_ie});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic bus(input logic [1:0] idx, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd);
    logic [31:0] a;
    a        = $urandom;
    a[3:2]   = idx;
    enable    = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    cycle();
    check("bus_ready_rise", {31'h0, mem_ready}, 32'h1);
    rd        = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    cycle();
    check("bus_ready_fall", {31'h0, mem_ready}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    int k, pulses;
    reset = 1'b1; enable = 1'b0; mem_valid = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    idle(2);
    reset = 1'b0;

    // Reset values
    bus(2'd0, 32'h0, 4'h0, rd); check("rst_count", rd, 32'h0);
    bus(2'd1, 32'h0, 4'h0, rd); check("rst_compare", rd, 32'hFFFFFFFF);
    bus(2'd2, 32'h0, 4'h0, rd); check("rst_ctrl", rd, 32'h0);
    bus(2'd3, 32'h0, 4'h0, rd); check("rst_status", rd, 32'h0);

    // Periodic match with interrupt
    bus(2'd0, 32'h0, 4'hF, rd);
    bus(2'd1, 32'd3, 4'hF, rd);
    bus(2'd2, 32'h7, 4'hF, rd);
    k = 0;
    while (irq !== 1'b1 && k < 100) begin cycle(); k++; end
    check("periodic_irq_latency", 32'(k), 32'd15);
    bus(2'd0, 32'h0, 4'h0, rd); check("periodic_reload", rd, 32'h0);
    bus(2'd3, 32'h1, 4'h1, rd);
    check("w1c_irq_low", {31'h0, irq}, 32'h0);

    // One-shot across the 32-bit wrap
    bus(2'd2, 32'h0, 4'hF, rd);
    bus(2'd3, 32'h1, 4'hF, rd);
    bus(2'd0, 32'hFFFFFFFE, 4'hF, rd);
    bus(2'd1, 32'd5, 4'hF, rd);
    bus(2'd2, 32'h1, 4'hF, rd);
    idle(14);
    bus(2'd3, 32'h0, 4'h0, rd); check("wrap_no_match", rd, 32'h0);
    idle(40);
    bus(2'd3, 32'h0, 4'h0, rd); check("oneshot_match", rd, 32'h1);

    // Byte-masked COUNT write
    bus(2'd2, 32'h0, 4'hF, rd);
    bus(2'd0, 32'h12345678, 4'hF, rd);
    bus(2'd0, 32'h0000AB00, 4'b0010, rd);
    bus(2'd0, 32'h0, 4'h0, rd); check("byte_mask", rd, 32'h1234AB78);

    // Held mem_valid
    enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'h0; mem_wstrb = 4'h0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin cycle(); if (mem_ready) pulses++; end
    check("held_valid_pulses", 32'(pulses), 32'd3);
    mem_valid = 1'b0; cycle();
    enable = 1'b0; mem_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin cycle(); if (mem_ready) pulses++; end
    check("disabled_pulses", 32'(pulses), 32'd0);
    mem_valid = 1'b0; enable = 1'b1; cycle();

    // W1C colliding with a match tick
    bus(2'd3, 32'h1, 4'hF, rd);
    bus(2'd1, 32'd10, 4'hF, rd);
    bus(2'd0, 32'd10, 4'hF, rd);
    bus(2'd2, 32'h1, 4'hF, rd);
    idle(2);
    bus(2'd3, 32'h1, 4'h1, rd);
    bus(2'd3, 32'h0, 4'h0, rd); check("match_beats_w1c", rd, 32'h1);
    bus(2'd2, 32'h0, 4'hF, rd);
    bus(2'd3, 32'h1, 4'h1, rd);
    bus(2'd3, 32'h0, 4'h0, rd); check("w1c_clears", rd, 32'h0);

    // Reset abandons an accepted transaction
    enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'h4; mem_wstrb = 4'h0; reset = 1'b1;
    cycle();
    check("reset_no_ready", {31'h0, mem_ready}, 32'h0);
    reset = 1'b0; mem_valid = 1'b0;
    cycle();
    check("reset_still_no_ready", {31'h0, mem_ready}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      enable    = ($urandom_range(0, 4) != 0);
      mem_valid = ($urandom_range(0, 4) < 3);
      mem_addr  = $urandom;
      mem_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      mem_wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
      cycle();
    end
    reset = 1'b0; mem_valid = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
